alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU between two requesters, e.g. the execute stage and a
//  branch/address helper. Round-robin arbitration picks a requester and registers its
//  operands. One cycle later the ALU result is registered and returned on that
//  requester's response channel. Opcodes are the 4-bit `ALU_CTL_* codes from Const.v.
// PARAMETERS
//  DATA_W  32  operand/result width (must match ALU width)
//  CTL_W   4   ALU control code width
// PORTS
//  clk_i        in   1       clock, all state on rising edge
//  rst_i        in   1       synchronous reset, active-high
//  rN_valid_i   in   1       requester N (N=0,1) has an operation pending
//  rN_ready_o   out  1       requester N operation accepted this cycle
//  rN_ctl_i     in   CTL_W   ALU control code from requester N
//  rN_op1_i     in   DATA_W  operand 1 from requester N
//  rN_op2_i     in   DATA_W  operand 2 from requester N
//  rN_rvalid_o  out  1       result for requester N is valid
//  rN_rready_i  in   1       requester N consumes the result
//  rN_res_o     out  DATA_W  result for requester N (shared result register)
//  alu_ctl_o    out  CTL_W   to ALU control input (registered)
//  alu_op1_o    out  DATA_W  to ALU operand 1 (registered)
//  alu_op2_o    out  DATA_W  to ALU operand 2 (registered)
//  alu_res_i    in   DATA_W  from ALU result
//  busy_o       out  1       high whenever state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE -> EXEC -> RESP -> IDLE.
//  - Reset: state=IDLE; ctl/op1/op2/result regs=0; owner=0; last_grant=1, so r0 wins first.
//    All ready/rvalid outputs=0 and busy_o=0.
//  - IDLE: grant = the requester with valid_i high.
//    If both are valid, grant = !last_grant (round-robin).
//  - IDLE, accept: rG_ready_o=1 combinationally (only in IDLE, only for the granted
//    requester, only while its valid_i is high).
//    On that edge: capture ctl/op1/op2, owner<=G, last_grant<=G, go to EXEC.
//  - Requester handshake: valid_i and payload are held stable until ready_o.
//    Dropping valid before ready is permitted and simply withdraws the request.
//  - EXEC: alu_*_o show the captured operands. result<=alu_res_i at the end of the cycle.
//    Go to RESP.
//  - RESP: r<owner>_rvalid_o=1 and the other rvalid_o=0.
//    If r<owner>_rready_i: go to IDLE, else hold RESP (result stable).
//  - Latency: accept edge T; EXEC during T+1; rvalid high from T+2.
//    Result = ALU(ctl, op1, op2) exactly as captured; widths pass through, no extension.
//  - rN_res_o: both ports are driven from the single result register; only the owner's
//    rvalid qualifies it.
//  - No ready is asserted outside IDLE. The non-owner waits with no loss of its request.
//  - Reset mid-operation (EXEC/RESP): the in-flight operation is discarded, no rvalid is
//    produced, and all state returns to its reset value.
//  - last_grant changes only on an accept. A lone requester is served repeatedly without
//    waiting on the idle one.
// CONFIGURATION
//  ALU_ARB_B2B_EN defined:
//    In RESP, when the owner's rready_i=1 and some valid_i is high, arbitrate in the same
//    cycle: assert that ready_o, capture the new operands and go directly to EXEC.
//    Throughput is one op per 2 cycles. Arbitration rules are as in IDLE.
//  ALU_ARB_B2B_EN undefined:
//    RESP always returns to IDLE. ready_o is never asserted in RESP.
//    Throughput is one op per 3 cycles.
// TESTING
//  1. Reset, then r0: ADD 5,7 -> r0_ready at T, alu_op1/op2=5/7 at T+1,
//     r0_rvalid and res=12 at T+2.
//  2. r1: SUB 3,5; SLT 0xFFFFFFFF,1 -> res=0xFFFFFFFE, then res=1;
//     r1_rvalid only, r0_rvalid stays 0.
//  3. r0 and r1 valid every cycle for 4 ops -> grants alternate r0,r1,r0,r1
//     (r0 first after reset); each result matches its own operands.
//  4. Hold rN_rready_i=0 for 5 cycles in RESP -> rvalid and res stable, no ready_o asserted,
//     busy_o=1; release -> IDLE next cycle.
//  5. Assert rst_i during EXEC of XOR 0xF0,0x0F -> next cycle all outputs are reset values;
//     no rvalid ever appears for that op.
//  6. With ALU_ARB_B2B_EN and r0 streaming OR ops with rready=1 -> accepts every 2 cycles.
//     Without the macro -> accepts every 3 cycles.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU by two requesters; ALU_ARB_B2B_EN enables RESP->EXEC back-to-back issue
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_valid_i,
  output logic              r0_ready_o,
  input  logic [CTL_W-1:0]  r0_ctl_i,
  input  logic [DATA_W-1:0] r0_op1_i,
  input  logic [DATA_W-1:0] r0_op2_i,
  output logic              r0_rvalid_o,
  input  logic              r0_rready_i,
  output logic [DATA_W-1:0] r0_res_o,
  input  logic              r1_valid_i,
  output logic              r1_ready_o,
  input  logic [CTL_W-1:0]  r1_ctl_i,
  input  logic [DATA_W-1:0] r1_op1_i,
  input  logic [DATA_W-1:0] r1_op2_i,
  output logic              r1_rvalid_o,
  input  logic              r1_rready_i,
  output logic [DATA_W-1:0] r1_res_o,
  output logic [CTL_W-1:0]  alu_ctl_o,
  output logic [DATA_W-1:0] alu_op1_o,
  output logic [DATA_W-1:0] alu_op2_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [CTL_W-1:0] ctl_q, ctl_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic owner_q, owner_d, last_q, last_d;
  logic grant, own_rr, arb_en, acc;
  assign grant  = (r0_valid_i & r1_valid_i) ? ~last_q : r1_valid_i;
  assign own_rr = owner_q ? r1_rready_i : r0_rready_i;
`ifdef ALU_ARB_B2B_EN
  assign arb_en = (state_q == IDLE) | ((state_q == RESP) & own_rr);
`else
  assign arb_en = state_q == IDLE;
`endif
  assign acc         = arb_en & (r0_valid_i | r1_valid_i);
  assign r0_ready_o  = acc & ~grant;
  assign r1_ready_o  = acc & grant;
  assign r0_rvalid_o = (state_q == RESP) & ~owner_q;
  assign r1_rvalid_o = (state_q == RESP) & owner_q;
  assign r0_res_o    = res_q;
  assign r1_res_o    = res_q;
  assign alu_ctl_o   = ctl_q;
  assign alu_op1_o   = op1_q;
  assign alu_op2_o   = op2_q;
  assign busy_o      = state_q != IDLE;
  always_comb begin
    ctl_d   = acc ? (grant ? r1_ctl_i : r0_ctl_i) : ctl_q;
    op1_d   = acc ? (grant ? r1_op1_i : r0_op1_i) : op1_q;
    op2_d   = acc ? (grant ? r1_op2_i : r0_op2_i) : op2_q;
    owner_d = acc ? grant : owner_q;
    last_d  = acc ? grant : last_q;
    res_d   = (state_q == EXEC) ? alu_res_i : res_q;
    state_d = acc ? EXEC : (state_q == EXEC) ? RESP : ((state_q == RESP) && own_rr) ? IDLE : state_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end
endmodule
